// File: rtl/sm3_msg_feeder_if.sv
// Byte stream with valid/ready handshake and a last marker.
// master drives valid/data/last; slave drives ready.
interface sm3_msg_feeder_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/sm3_msg_feeder.sv
// sm3_msg_feeder: streams a message into the SM3 core's byte command port,
// waits for the digest and returns it as 32 bytes, MSB first.
// Optional watchdog on the digest wait: define SM3_FEEDER_WATCHDOG_EN.
module sm3_msg_feeder #(
    parameter int unsigned MAX_MSG_BYTES  = 1048576,
    parameter int unsigned CLEAR_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sm3_msg_feeder_if.slave         s_bus,
    sm3_msg_feeder_if.master        m_bus,
    output logic [1:0]              core_cmd_o,
    output logic [7:0]              core_byte_o,
    input  logic                    core_busy_i,
    input  logic [255:0]            core_digest_i,
    input  logic                    core_digest_valid_i,
    output logic [63:0]             msg_len_o,
    output logic                    err_o
);
    localparam int unsigned CNT_W = $clog2(MAX_MSG_BYTES) + 1;
    localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [1:0] CMD_CLEAR  = 2'd0;
    localparam logic [1:0] CMD_BYTE   = 2'd1;
    localparam logic [1:0] CMD_FINISH = 2'd2;
    localparam logic [1:0] CMD_HOLD   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_FINISH,
        ST_WAIT,
        ST_DRAIN,
        ST_ABORT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CLR_W-1:0]   clr_q, clr_d;
    logic [4:0]         idx_q, idx_d;
    logic [255:0]       shift_q, shift_d;
    logic [63:0]        msg_len_q, msg_len_d;
    logic               err_q, err_d;
    logic               s_ready_c;

`ifdef SM3_FEEDER_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0]    wd_q, wd_d;
`else
    // Timeout only matters with the watchdog built in.
    logic               unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            clr_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            msg_len_q <= '0;
            err_q     <= 1'b0;
`ifdef SM3_FEEDER_WATCHDOG_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            clr_q     <= clr_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            msg_len_q <= msg_len_d;
            err_q     <= err_d;
`ifdef SM3_FEEDER_WATCHDOG_EN
            wd_q      <= wd_d;
`endif
        end
    end

    // Next-state logic and core command decode.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        clr_d       = clr_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        msg_len_d   = msg_len_q;
        err_d       = err_q;
        core_cmd_o  = CMD_HOLD;
        core_byte_o = 8'h00;
        s_ready_c   = 1'b0;
`ifdef SM3_FEEDER_WATCHDOG_EN
        wd_d        = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                // The first byte is left on the bus; it is taken in STREAM.
                if (s_bus.valid) begin
                    state_d = ST_CLEAR;
                    err_d   = 1'b0;
                    count_d = '0;
                    clr_d   = '0;
                end
            end
            ST_CLEAR: begin
                core_cmd_o = CMD_CLEAR;
                clr_d      = clr_q + CLR_W'(1);
                if (clr_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                s_ready_c = !core_busy_i;
                if (s_bus.valid && s_ready_c) begin
                    // Bytes beyond the limit are swallowed so the sender can finish.
                    if (count_q == CNT_W'(MAX_MSG_BYTES)) begin
                        err_d = 1'b1;
                    end else begin
                        core_cmd_o  = CMD_BYTE;
                        core_byte_o = s_bus.data;
                        count_d     = count_q + CNT_W'(1);
                    end
                    if (s_bus.last) begin
                        state_d   = ST_FINISH;
                        msg_len_d = 64'(count_d) << 3;
                    end
                end
            end
            ST_FINISH: begin
                core_cmd_o = core_busy_i ? CMD_HOLD : CMD_FINISH;
                if (core_digest_valid_i) begin
                    state_d = ST_WAIT;
                end
`ifdef SM3_FEEDER_WATCHDOG_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ABORT;
                    err_d   = 1'b1;
                    clr_d   = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            ST_WAIT: begin
                shift_d = core_digest_i;
                idx_d   = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (m_bus.ready) begin
                    shift_d = {shift_q[247:0], 8'h00};
                    idx_d   = idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        state_d = ST_IDLE;
                    end
                end
            end
`ifdef SM3_FEEDER_WATCHDOG_EN
            ST_ABORT: begin
                // Reset the core after a lost digest, then go idle.
                core_cmd_o = CMD_CLEAR;
                clr_d      = clr_q + CLR_W'(1);
                if (clr_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Digest stream driven straight from the shift register.
    assign m_bus.valid = (state_q == ST_DRAIN);
    assign m_bus.data  = (state_q == ST_DRAIN) ? shift_q[255:248] : 8'h00;
    assign m_bus.last  = (state_q == ST_DRAIN) && (idx_q == 5'd31);
    assign s_bus.ready = s_ready_c;
    assign msg_len_o   = msg_len_q;
    assign err_o       = err_q;
endmodule
